ps2_key_event_ctrl: RTL
=======================

# ps2_key_event_ctrl

System-clock-domain PS/2 keyboard front end: samples the raw PS/2 clock/data pins, frames and checks 11-bit packets, and sequences scan-code bytes into complete key events (make/break, extended). Events queue in a small FIFO and leave on a valid/ready interface to the host logic. It supersedes direct use of the PS/2-clock-domain byte receiver, so downstream logic sees one clock and whole key events rather than raw bytes.

## Interface
- `TIMEOUT_CYCLES`, 10000, system clocks without a falling PS/2 clock edge before an open frame is abandoned (200 us at 50 MHz).
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `ps2_clock`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head when `evt_valid` is also high.
- `evt_code`  out  8  scan code of the head event.
- `evt_ext`  out  1  head event was prefixed by E0.
- `evt_release`  out  1  head event was prefixed by F0 (break).
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout failure.
- `overflow`  out  1  sticky; set when an event is dropped on a full FIFO; cleared only by reset.

## Operation
- Input stage: 2-FF synchronizer on both pins, plus a registered copy of the synced clock. A falling edge is registered-high followed by synced-low, giving a one-cycle `fall` strobe.
- Frame FSM states:
  - IDLE: on `fall` with data = 0 (start bit), go to RECV with bit count = 1. On `fall` with data = 1, ignore the edge; no error.
  - RECV: each `fall` shifts data into an 11-bit shift register, LSB first, and increments the count.
  - On the 11th bit, check stop = 1 and odd parity (XOR of the 8 data bits and the parity bit = 1).
  - Pass: one-cycle `byte_done` with the byte, then IDLE.
  - Fail: pulse `frame_err`, then IDLE.
- Timeout: a counter clears on every `fall` and counts only in RECV. When it reaches `TIMEOUT_CYCLES-1`, pulse `frame_err` and go to IDLE.
- Decoder FSM states: BASE, EXT, REL, EXT_REL. It acts on `byte_done` only.
  - E0: BASE→EXT; EXT stays EXT; REL→EXT_REL; EXT_REL stays.
  - F0: BASE→REL; EXT→EXT_REL; REL and EXT_REL stay.
  - Control bytes 00, AA, EE, FA, FE, FF: dropped, no event, state → BASE.
  - Any other byte: push event {code, ext, release}, where ext is set in EXT/EXT_REL and release in REL/EXT_REL; state → BASE.
  - E1 (Pause) is not decoded; it is emitted as an ordinary code.
  - Any `frame_err` forces the decoder to BASE.
- FIFO:
  - Pop occurs when `evt_valid && evt_ready`.
  - A push on full is dropped and sets `overflow`, unless a pop happens in the same cycle; then both succeed and occupancy is unchanged.
  - A push on empty with no pop leaves occupancy at 1.
  - Pointers wrap modulo `FIFO_DEPTH`; occupancy is a `$clog2(FIFO_DEPTH)+1`-bit count.
  - The head outputs are stable while `evt_valid && !evt_ready`.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_release`=0, `frame_err`=0, `overflow`=0.
  - Frame FSM in IDLE; decoder in BASE; FIFO empty; sync registers = 1 (bus idle).
- Reset mid-frame discards the partial frame and any pending prefixes; there is no `frame_err` pulse.
- Pin falling edge to `fall`: 3 clk.
- `fall` of the stop bit in cycle N: `byte_done` or `frame_err` in N+1, FIFO write in N+2, `evt_valid` high in N+3 if the FIFO was empty.
- `evt_valid` drops the cycle after the pop of the last entry.
- A prefix byte followed by a frame error produces no event.

## Structure
- Package `ps2_pkg` holds:
  - byte constants: `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, and the control-byte list;
  - `FRAME_BITS`=11;
  - frame state enum {IDLE, RECV};
  - decoder state enum {BASE, EXT, REL, EXT_REL};
  - event struct {release, ext, code[7:0]}.
- Sub-module `ps2_evt_fifo`: synchronous FIFO parameterized on `FIFO_DEPTH`, holding a 10-bit event, with `overflow` logic.

## Test plan
- Frame 0x1C with correct parity and stop, `evt_ready`=1 → one event {code 1C, ext 0, release 0}, `evt_valid` pulses exactly once.
- Sequence E0, F0, 0x75 → single event {75, ext 1, release 1}; decoder returns to BASE.
- 0x1C frame with wrong parity → `frame_err` pulse, no event. A following 0x1C good frame → event {1C, 0, 0}.
- Start bit plus 4 bits, then idle for `TIMEOUT_CYCLES` → `frame_err` after the timeout. The next full frame 0x32 decodes correctly.
- `evt_ready`=0, six good frames sent → 4 events held, `overflow`=1. Draining yields the first four codes in order.
- FIFO full, a push coincides with `evt_ready`=1 → occupancy stays at 4, no overflow set. Then assert reset mid-frame → all outputs 0 the next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key event front end.
//   - scan-code prefix bytes and the list of keyboard control bytes
//   - frame length, frame/decoder state enums, key event struct
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Keyboard replies (ack, BAT ok, echo, resend, errors) that never form a key.
    localparam logic [7:0] PS2_CTRL [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    localparam int FRAME_BITS = 11;

    typedef enum logic {IDLE, RECV} frame_state_t;

    typedef enum logic [1:0] {BASE, EXT, REL, EXT_REL} dec_state_t;

    // 'release' is a reserved word, so the break flag is called rel.
    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic is_ctrl(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 6; i++)
            if (b == PS2_CTRL[i]) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous event FIFO with sticky overflow flag.
//   clk, reset   : system clock, synchronous active-high reset
//   push, wdata  : write request and 10-bit event
//   ready        : consumer accepts head when valid
//   valid, rdata : head present / head event (zero when empty)
//   overflow     : sticky, set when a push is dropped on a full FIFO
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [9:0] wdata,
    input  logic       ready,
    output logic       valid,
    output logic [9:0] rdata,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en;

    assign full  = (count == FULL_CNT);
    assign valid = (count != '0);
    assign pop   = valid & ready;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign wr_en = push & (~full | pop);
    assign rdata = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 keyboard front end in the system clock domain.
//   clk, reset             : system clock, synchronous active-high reset
//   ps2_clock, ps2_data    : raw asynchronous PS/2 pins
//   evt_valid/evt_ready    : event handshake to host
//   evt_code/ext/release   : head event fields
//   frame_err              : one-cycle pulse on parity/stop/timeout failure
//   overflow               : sticky event-drop flag
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- input synchronizer ----------------
    logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2, fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            {clk_s1, clk_s2, clk_d} <= 3'b111;
            {dat_s1, dat_s2}        <= 2'b11;
        end else begin
            {clk_s1, clk_s2, clk_d} <= {ps2_clock, clk_s1, clk_s2};
            {dat_s1, dat_s2}        <= {ps2_data, dat_s1};
        end
    end

    assign fall = clk_d & ~clk_s2;

    // ---------------- frame FSM ----------------
    frame_state_t fstate, fstate_nxt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [10:0]   frame;
    logic [TW-1:0] tmo_cnt;
    logic          last_bit, frame_ok, tmo_hit, done_nxt, err_nxt;
    logic          byte_done;
    logic [7:0]    byte_val;

    // Frame as it stands once the current bit is shifted in (LSB first).
    assign frame    = {dat_s2, shreg};
    assign last_bit = fall && (bit_cnt == 4'(FRAME_BITS - 1));
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) fstate <= IDLE;
        else       fstate <= fstate_nxt;
    end

    always_comb begin
        fstate_nxt = fstate;
        case (fstate)
            IDLE: if (fall && !dat_s2) fstate_nxt = RECV;
            RECV: if (last_bit || (!fall && tmo_hit)) fstate_nxt = IDLE;
            default: fstate_nxt = IDLE;
        endcase
    end

    always_comb begin
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (fstate == RECV) begin
            done_nxt = last_bit & frame_ok;
            err_nxt  = (last_bit & ~frame_ok) | (~fall & tmo_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            byte_done <= 1'b0;
            byte_val  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (fall) begin
                shreg   <= frame[10:1];
                bit_cnt <= (fstate == IDLE) ? 4'd1 : bit_cnt + 4'd1;
                tmo_cnt <= '0;
            end else if (fstate == RECV) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            byte_done <= done_nxt;
            byte_val  <= frame[8:1];
            frame_err <= err_nxt;
        end
    end

    // ---------------- scan-code decoder FSM ----------------
    dec_state_t dstate, dstate_nxt;
    ps2_evt_t   evt_nxt, evt_data, head;
    logic       push_nxt, evt_push;
    logic [9:0] head_raw;

    always_ff @(posedge clk) begin
        if (reset) dstate <= BASE;
        else       dstate <= dstate_nxt;
    end

    always_comb begin
        dstate_nxt = dstate;
        if (frame_err) begin
            dstate_nxt = BASE;
        end else if (byte_done) begin
            if (byte_val == PS2_EXT)
                dstate_nxt = (dstate == BASE) ? EXT :
                             (dstate == REL)  ? EXT_REL : dstate;
            else if (byte_val == PS2_BRK)
                dstate_nxt = (dstate == BASE) ? REL :
                             (dstate == EXT)  ? EXT_REL : dstate;
            else
                dstate_nxt = BASE;
        end
    end

    always_comb begin
        push_nxt     = byte_done && (byte_val != PS2_EXT) && (byte_val != PS2_BRK)
                       && !is_ctrl(byte_val);
        evt_nxt.rel  = (dstate == REL) || (dstate == EXT_REL);
        evt_nxt.ext  = (dstate == EXT) || (dstate == EXT_REL);
        evt_nxt.code = byte_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_push <= 1'b0;
            evt_data <= '0;
        end else begin
            evt_push <= push_nxt;
            evt_data <= evt_nxt;
        end
    end

    // ---------------- event FIFO ----------------
    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (evt_push),
        .wdata    (evt_data),
        .ready    (evt_ready),
        .valid    (evt_valid),
        .rdata    (head_raw),
        .overflow (overflow)
    );

    assign head        = ps2_evt_t'(head_raw);
    assign evt_code    = head.code;
    assign evt_ext     = head.ext;
    assign evt_release = head.rel;

endmodule
